// File: rtl/pixel_out_buffer.sv
// rtl/pixel_out_buffer.sv - first-word-fall-through output pixel buffer; OUT_TLAST_EN adds the o_last end-of-line marker
module pixel_out_buffer #(
   parameter int DATA_WIDTH  = 8,
   parameter int DEPTH       = 16,
   parameter int AFULL_LEVEL = 12,
   parameter int LINE_PIXELS = 512
) (
   input  logic                     aclk,
   input  logic                     areset,
   input  logic [DATA_WIDTH-1:0]    i_data,
   input  logic                     i_data_valid,
   output logic [DATA_WIDTH-1:0]    o_data,
   output logic                     o_data_valid,
   input  logic                     i_data_ready,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_almost_full,
   output logic                     o_overflow
`ifdef OUT_TLAST_EN
   ,
   output logic                     o_last
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [AW-1:0]         rd_ptr_n;
   logic [CW-1:0]         count_n;
   logic [DATA_WIDTH-1:0] head_n;
   logic                  rd_en;
   logic                  wr_en;
   logic                  drop;

   always_comb begin
      rd_en    = o_data_valid && i_data_ready;
      wr_en    = i_data_valid && ((o_count != CW'(DEPTH)) || rd_en);
      drop     = i_data_valid && !wr_en;
      rd_ptr_n = rd_en ? rd_ptr + AW'(1) : rd_ptr;
      count_n  = o_count + CW'(wr_en) - CW'(rd_en);
      // The next head is bypassed from i_data when it lands in the slot about to be presented.
      head_n   = (wr_en && (wr_ptr == rd_ptr_n)) ? i_data : mem[rd_ptr_n];
   end

   always_ff @(posedge aclk) begin
      if (!areset && wr_en) begin
         mem[wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         o_count       <= '0;
         o_data        <= '0;
         o_data_valid  <= 1'b0;
         o_almost_full <= 1'b0;
         o_overflow    <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         rd_ptr        <= rd_ptr_n;
         o_count       <= count_n;
         o_data_valid  <= (count_n != '0);
         o_almost_full <= (int'(count_n) >= AFULL_LEVEL);
         if (count_n != '0) begin
            o_data <= head_n;
         end
         if (drop) begin
            o_overflow <= 1'b1;
         end
      end
   end

`ifdef OUT_TLAST_EN
   localparam int LW = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;

   logic [LW-1:0] line_cnt;
   logic [LW-1:0] line_cnt_n;

   always_comb begin
      line_cnt_n = line_cnt;
      if (rd_en) begin
         line_cnt_n = (line_cnt == LW'(LINE_PIXELS - 1)) ? '0 : line_cnt + LW'(1);
      end
   end

   // o_last tracks the pixel that will be on o_data next cycle, i.e. transfer index line_cnt_n.
   always_ff @(posedge aclk) begin
      if (areset) begin
         line_cnt <= '0;
         o_last   <= 1'b0;
      end else begin
         line_cnt <= line_cnt_n;
         o_last   <= (count_n != '0) && (line_cnt_n == LW'(LINE_PIXELS - 1));
      end
   end
`endif

endmodule
